// File: rtl/lift_shaft_model_pkg.sv
// Shared types, direction encoding and sensor decode helpers for the lift shaft plant model.
package lift_pkg;

    typedef enum logic [1:0] {
        AT_FLOOR = 2'd0,
        GAP1     = 2'd1,
        MID      = 2'd2,
        GAP2     = 2'd3
    } shaft_state_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Sensor vectors are decoded at full width and then sized down by the caller.
    localparam int OH_IW = 5;
    localparam int OH_W  = 32;

    function automatic logic [OH_W-1:0] onehot(input logic [OH_IW-1:0] idx);
        logic [OH_W-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

    function automatic int pos_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lift_shaft_model_if.sv
// Controller <-> shaft signal bundle: the controller drives motor/door commands, the shaft drives sensors.
interface lift_shaft_if
    import lift_pkg::*;
#(
    parameter int N = 3
) ();

    localparam int PW = pos_width(N);

    logic          up;
    logic          stop;
    logic          door;
    logic [N-1:0]  sf;
    logic [N-2:0]  si;
    logic [PW-1:0] pos;
    logic          moving;
    logic          fault;

    modport master (
        output up, stop, door,
        input  sf, si, pos, moving, fault
    );

    modport slave (
        input  up, stop, door,
        output sf, si, pos, moving, fault
    );

endinterface

// File: rtl/lift_shaft_model_travel_timer.sv
// Loadable down-counter pacing each traversal phase; done is high whenever the count sits at zero.
module lift_travel_timer
    import lift_pkg::*;
#(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/lift_shaft_model.sv
// Plant model of a lift car in its shaft, turning motor/door commands into floor and midway sensors.
// Optional sticky illegal-command detection is built when LIFT_SHAFT_FAULT_EN is defined.
module lift_shaft_model
    import lift_pkg::*;
#(
    parameter int N          = 3,
    parameter int GAP_CYCLES = 20,
    parameter int MID_CYCLES = 5,
    parameter int INIT_FLOOR = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    lift_shaft_if.slave   shaft
);

    localparam int PW   = pos_width(N);
    localparam int SIW  = N - 1;
    localparam int TMAX = (GAP_CYCLES > MID_CYCLES) ? GAP_CYCLES : MID_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);

    shaft_state_e  state_q, state_d;
    logic [PW-1:0] pos_q, pos_d;
    logic          dir_q, dir_d;

    logic          tmr_load;
    logic [TW-1:0] tmr_val;
    logic          tmr_done;

    logic          at_floor;
    logic          legal;
    logic          go;
    logic [PW-1:0] mid_idx;
    logic [N-1:0]  sf_dec;
    logic [SIW-1:0] si_dec;

    lift_travel_timer #(
        .W (TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .done_o     (tmr_done)
    );

    assign at_floor = (state_q == AT_FLOOR);
    assign legal    = shaft.up ? (pos_q < PW'(N - 1)) : (pos_q != '0);
    assign go       = at_floor && !shaft.stop && !shaft.door && legal;

    // Commands are only sampled at a floor; once departed the car always completes the traversal.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        dir_d    = dir_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        case (state_q)
            AT_FLOOR: begin
                if (go) begin
                    state_d  = GAP1;
                    dir_d    = shaft.up ? DIR_UP : DIR_DN;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYCLES - 1);
                end
            end
            GAP1: begin
                if (tmr_done) begin
                    state_d  = MID;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(MID_CYCLES - 1);
                end
            end
            MID: begin
                if (tmr_done) begin
                    state_d  = GAP2;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(GAP_CYCLES - 1);
                end
            end
            GAP2: begin
                if (tmr_done) begin
                    state_d = AT_FLOOR;
                    pos_d   = (dir_q == DIR_UP) ? pos_q + PW'(1) : pos_q - PW'(1);
                end
            end
            default: begin
                state_d = AT_FLOOR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= AT_FLOOR;
            pos_q   <= PW'(INIT_FLOOR);
            dir_q   <= DIR_UP;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            dir_q   <= dir_d;
        end
    end

    // Midway sensor index is the lower floor of the gap being crossed.
    assign mid_idx = (dir_q == DIR_UP) ? pos_q : pos_q - PW'(1);

    always_comb begin
        sf_dec = '0;
        si_dec = '0;
        if (at_floor) begin
            sf_dec = N'(onehot(OH_IW'(pos_q)));
        end
        if (state_q == MID) begin
            si_dec = SIW'(onehot(OH_IW'(mid_idx)));
        end
    end

    assign shaft.sf     = sf_dec;
    assign shaft.si     = si_dec;
    assign shaft.pos    = pos_q;
    assign shaft.moving = !at_floor;

`ifdef LIFT_SHAFT_FAULT_EN
    logic fault_q;
    logic fault_d;

    always_comb begin
        fault_d = fault_q;
        if (shaft.door && !at_floor) begin
            fault_d = 1'b1;
        end
        if (at_floor && !shaft.stop && !shaft.door && !legal) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign shaft.fault = fault_q;
`else
    assign shaft.fault = 1'b0;
`endif

endmodule
